// File: rtl/xmult_stream_ctrl.sv
// xmult_stream_ctrl
//   Host-side initiator for the X-multiplier compute unit. Software fills the
//   X buffer, pulses start with an element count, and this block streams the
//   X elements out over x_new/x_ack. It then pulls the same number of Y
//   results over y_req/y_valid into a Y buffer that software reads back.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start, n            launch pulse and element count (clamped to depth)
//   wr_en/wr_addr/wr_data   X buffer write port (ignored while busy)
//   rd_addr, rd_data    Y buffer read port, one cycle latency
//   x_elem, x_new, x_ack    X stream handshake toward the compute unit
//   y_avail, y_req, y_valid, y_elem   Y collection handshake
//   busy, done, err     transfer status (done/err held until next start)
//   x_count, y_count    elements moved in the current transfer
module xmult_stream_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [10:0]       n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] x_elem,
  output logic              x_new,
  input  logic              x_ack,
  input  logic              y_avail,
  output logic              y_req,
  input  logic              y_valid,
  input  logic [DATA_W-1:0] y_elem,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [10:0]       x_count,
  output logic [10:0]       y_count
);

  localparam int          DEPTH_I = 1 << ADDR_W;
  localparam logic [10:0] DEPTH   = 11'(DEPTH_I);
  localparam int          WCNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, XRD, XSEND, YWAIT, YREQ, YGAP, DONE, ERR} state_t;

  state_t              state;
  logic [10:0]         n_lat;
  logic [10:0]         n_clamp;
  logic [WCNT_W-1:0]   wcnt;
  logic                wcnt_hit;
  logic                y_we;
  logic [DATA_W-1:0]   xbuf [DEPTH_I];
  logic [DATA_W-1:0]   ybuf [DEPTH_I];

  assign n_clamp  = (n > DEPTH) ? DEPTH : n;
  // Last idle cycle before timeout: the transition fires on this edge.
  assign wcnt_hit = (wcnt == WCNT_W'(TIMEOUT - 1));
  assign y_we     = !reset && (state == YREQ) && y_valid;

  // X buffer: software-owned, frozen while a transfer is running.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) xbuf[wr_addr] <= wr_data;
  end

  // x_elem doubles as the X buffer read register; it is loaded in XRD and
  // holds through XSEND so the element is stable while x_new is high.
  always_ff @(posedge clk) begin
    if (reset)             x_elem <= '0;
    else if (state == XRD) x_elem <= xbuf[x_count[ADDR_W-1:0]];
  end

  // Y buffer: read-before-write, so a colliding read returns old data.
  always_ff @(posedge clk) begin
    if (y_we) ybuf[y_count[ADDR_W-1:0]] <= y_elem;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= ybuf[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      n_lat   <= '0;
      wcnt    <= '0;
      x_new   <= 1'b0;
      y_req   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      x_count <= '0;
      y_count <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            n_lat   <= n_clamp;
            x_count <= '0;
            y_count <= '0;
            err     <= 1'b0;
            if (n_clamp == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= XRD;
              done  <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end
        XRD: begin
          state <= XSEND;
          x_new <= 1'b1;
          wcnt  <= '0;
        end
        XSEND: begin
          if (x_ack) begin
            x_new   <= 1'b0;
            x_count <= x_count + 11'd1;
            wcnt    <= '0;
            state   <= (x_count + 11'd1 == n_lat) ? YWAIT : XRD;
          end else if (wcnt_hit) begin
            state <= ERR;
            x_new <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        YWAIT: begin
          if (y_avail) begin
            state <= YREQ;
            y_req <= 1'b1;
            wcnt  <= '0;
          end else if (wcnt_hit) begin
            state <= ERR;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        YREQ: begin
          if (y_valid) begin
            y_req   <= 1'b0;
            y_count <= y_count + 11'd1;
            if (y_count + 11'd1 == n_lat) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= YGAP;
            end
          end else if (wcnt_hit) begin
            state <= ERR;
            y_req <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        YGAP: begin
          state <= YREQ;
          y_req <= 1'b1;
          wcnt  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
